// File: rtl/regchk_pkg.sv
// Shared types and width helpers for the register-file checker.
// Entry field widths here set the checker's DATA_WIDTH/REG_ADDR_W defaults.
package regchk_pkg;

  localparam int CHK_DATA_W = 32;
  localparam int CHK_REG_W  = 5;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    READ,
    CMP,
    DONE
  } state_t;

  typedef struct packed {
    logic [CHK_REG_W-1:0]  reg_num;
    logic [CHK_DATA_W-1:0] val;
  } chk_entry_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/regchk_table.sv
// Check-table RAM: one synchronous write port, one asynchronous read port.
module regchk_table
  import regchk_pkg::*;
#(
  parameter int NUM_CHECKS = 16
) (
  input  logic                          clock,
  input  logic                          we,
  input  logic [idx_w(NUM_CHECKS)-1:0]  wr_idx,
  input  chk_entry_t                    wr_entry,
  input  logic [idx_w(NUM_CHECKS)-1:0]  rd_idx,
  output chk_entry_t                    rd_entry
);

  chk_entry_t mem [NUM_CHECKS];

  always_ff @(posedge clock) begin
    if (we) mem[wr_idx] <= wr_entry;
  end

  assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/regfile_checker.sv
// End-of-run register-file checker: waits RUN_CYCLES, then reads and compares each table entry.
// Optional macro REGCHK_STOP_ON_FAIL_EN ends the run at the first mismatch.
module regfile_checker
  import regchk_pkg::*;
#(
  parameter int DATA_WIDTH = CHK_DATA_W,
  parameter int REG_ADDR_W = CHK_REG_W,
  parameter int NUM_CHECKS = 16,
  parameter int RUN_CYCLES = 1000,
  parameter int READ_LAT   = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          tbl_we,
  input  logic [idx_w(NUM_CHECKS)-1:0]  tbl_idx,
  input  logic [REG_ADDR_W-1:0]         tbl_reg,
  input  logic [DATA_WIDTH-1:0]         tbl_val,
  input  logic [cnt_w(NUM_CHECKS)-1:0]  num_checks,
  output logic                          test,
  output logic                          t_ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0]         t_ctrl_readRegA,
  input  logic [DATA_WIDTH-1:0]         t_data_readRegA,
  output logic                          busy,
  output logic                          done,
  output logic [cnt_w(NUM_CHECKS)-1:0]  num_correct,
  output logic [cnt_w(NUM_CHECKS)-1:0]  num_failed,
  output logic                          fail_valid,
  output logic [REG_ADDR_W-1:0]         fail_reg,
  output logic [DATA_WIDTH-1:0]         fail_actual
);

  localparam int IW  = idx_w(NUM_CHECKS);
  localparam int CW  = cnt_w(NUM_CHECKS);
  localparam int RCW = $clog2(RUN_CYCLES + 1);
  localparam int LW  = $clog2(READ_LAT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(NUM_CHECKS);

  state_t          state, state_next;
  logic [CW-1:0]   count_q;
  logic [IW-1:0]   idx;
  logic [RCW-1:0]  cyc;
  logic [LW-1:0]   lat;
  chk_entry_t      wr_entry, rd_entry;
  logic            match, last;

  assign wr_entry = '{reg_num: tbl_reg, val: tbl_val};

  regchk_table #(.NUM_CHECKS(NUM_CHECKS)) u_table (
    .clock    (clock),
    .we       (tbl_we && (state == IDLE)),
    .wr_idx   (tbl_idx),
    .wr_entry (wr_entry),
    .rd_idx   (idx),
    .rd_entry (rd_entry)
  );

  assign match = (t_data_readRegA == rd_entry.val);
  assign last  = (CW'(idx) == count_q - CW'(1));

  assign test               = state inside {READ, CMP, DONE};
  assign busy               = state inside {RUN, READ, CMP};
  assign done               = (state == DONE);
  assign t_ctrl_writeEnable = 1'b0;
  assign t_ctrl_readRegA    = (state inside {READ, CMP}) ? rd_entry.reg_num : '0;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cyc == RCW'(RUN_CYCLES - 1))
                 state_next = (count_q == '0) ? DONE : READ;
      READ:    if (lat == LW'(READ_LAT - 1)) state_next = CMP;
      CMP: begin
        state_next = last ? DONE : READ;
`ifdef REGCHK_STOP_ON_FAIL_EN
        if (!match) state_next = DONE;
`endif
      end
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Counters, table index and the mismatch report all advance with the FSM state.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q     <= '0;
      idx         <= '0;
      cyc         <= '0;
      lat         <= '0;
      num_correct <= '0;
      num_failed  <= '0;
      fail_valid  <= 1'b0;
      fail_reg    <= '0;
      fail_actual <= '0;
    end else begin
      fail_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            count_q     <= (num_checks > MAX_CNT) ? MAX_CNT : num_checks;
            num_correct <= '0;
            num_failed  <= '0;
            cyc         <= '0;
          end
        end
        RUN: begin
          cyc <= cyc + RCW'(1);
          idx <= '0;
          lat <= '0;
        end
        READ: lat <= lat + LW'(1);
        CMP: begin
          lat <= '0;
          if (match) begin
            num_correct <= num_correct + CW'(1);
          end else begin
            num_failed  <= num_failed + CW'(1);
            fail_valid  <= 1'b1;
            fail_reg    <= rd_entry.reg_num;
            fail_actual <= t_data_readRegA;
          end
          if (!last) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
